// File: rtl/mem_arb_pkg.sv
// Shared types and defaults for the unified memory arbiter.
//   arb_state_t : arbiter FSM states (IDLE, I_BUSY, D_BUSY)
//   grant_t     : which port won the previous arbitration (GNT_I, GNT_D)
//   DEFAULT_TIMEOUT : busy cycles allowed without m_ack before abort
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    I_BUSY = 2'd1,
    D_BUSY = 2'd2
  } arb_state_t;

  typedef enum logic {
    GNT_I = 1'b0,
    GNT_D = 1'b1
  } grant_t;

  localparam int DEFAULT_TIMEOUT = 16;

endpackage

// File: rtl/arb_timeout_ctr.sv
// Watchdog counter for one memory access.
//   clk    : rising-edge clock
//   reset  : asynchronous, active-low reset
//   clear  : restart the count (new access granted)
//   enable : a busy cycle passed without m_ack
//   expire : combinational; high in the busy cycle that uses up the
//            last of the TIMEOUT allowed cycles
module arb_timeout_ctr
  import mem_arb_pkg::*;
#(
  parameter int TIMEOUT = DEFAULT_TIMEOUT
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic expire
);

  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT - 1);

  logic [CW-1:0] count_reg;

  assign expire = enable && (count_reg == LAST);

  // Holding at LAST on expiry avoids a wrap; the arbiter leaves the busy
  // state in the same cycle, so the value is never used again before clear.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_reg <= '0;
    end else if (clear) begin
      count_reg <= '0;
    end else if (enable && !expire) begin
      count_reg <= count_reg + 1'b1;
    end
  end

endmodule

// File: rtl/unified_mem_arbiter.sv
// Two-port (instruction / data) arbiter in front of one memory port.
//   clk, reset           : clock, asynchronous active-low reset
//   i_req/i_addr         : instruction fetch request, held until i_ready
//   i_rdata/i_ready      : fetched word, one-cycle completion pulse
//   d_req/d_we/d_addr/d_wdata : load/store request, held until d_ready
//   d_rdata/d_ready      : load word, one-cycle completion pulse
//   m_valid/m_we/m_addr/m_wdata : memory access, stable while busy
//   m_rdata/m_ack        : memory read data and one-cycle completion
//   bus_err              : sticky flag, set when an access times out
// Arbitration alternates when both ports ask; an access that sees no
// m_ack for TIMEOUT busy cycles completes with ERR_DATA.
module unified_mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int          TIMEOUT  = DEFAULT_TIMEOUT,
  parameter logic [31:0] ERR_DATA = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        i_req,
  input  logic [31:0] i_addr,
  output logic [31:0] i_rdata,
  output logic        i_ready,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic [31:0] d_rdata,
  output logic        d_ready,
  output logic        m_valid,
  output logic        m_we,
  output logic [31:0] m_addr,
  output logic [31:0] m_wdata,
  input  logic [31:0] m_rdata,
  input  logic        m_ack,
  output logic        bus_err
);

  arb_state_t state_reg;
  grant_t     last_grant_reg;

  logic i_live;
  logic d_live;
  logic pick_d;
  logic grant;
  logic ctr_enable;
  logic expire;

  // A requester keeps req high during its ready cycle; the pulse masks it
  // so the finished request is not served a second time.
  assign i_live = i_req && !i_ready;
  assign d_live = d_req && !d_ready;

  // Data wins when it is alone or when instruction had the last turn.
  assign pick_d = d_live && (!i_live || (last_grant_reg == GNT_I));
  assign grant  = (state_reg == IDLE) && (i_live || d_live);

  assign ctr_enable = (state_reg != IDLE) && !m_ack;

  arb_timeout_ctr #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk    (clk),
    .reset  (reset),
    .clear  (grant),
    .enable (ctr_enable),
    .expire (expire)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_reg      <= IDLE;
      last_grant_reg <= GNT_D;
      i_rdata        <= '0;
      i_ready        <= 1'b0;
      d_rdata        <= '0;
      d_ready        <= 1'b0;
      m_valid        <= 1'b0;
      m_we           <= 1'b0;
      m_addr         <= '0;
      m_wdata        <= '0;
      bus_err        <= 1'b0;
    end else begin
      i_ready <= 1'b0;
      d_ready <= 1'b0;
      case (state_reg)
        IDLE: begin
          // m_ack is ignored here: no access is outstanding.
          if (grant) begin
            m_valid <= 1'b1;
            if (pick_d) begin
              state_reg      <= D_BUSY;
              last_grant_reg <= GNT_D;
              m_addr         <= d_addr;
              m_we           <= d_we;
              m_wdata        <= d_wdata;
            end else begin
              state_reg      <= I_BUSY;
              last_grant_reg <= GNT_I;
              m_addr         <= i_addr;
              m_we           <= 1'b0;
              m_wdata        <= '0;
            end
          end
        end
        I_BUSY: begin
          // m_ack beats expiry when both land in the same cycle.
          if (m_ack) begin
            i_rdata   <= m_rdata;
            i_ready   <= 1'b1;
            m_valid   <= 1'b0;
            state_reg <= IDLE;
          end else if (expire) begin
            i_rdata   <= ERR_DATA;
            i_ready   <= 1'b1;
            bus_err   <= 1'b1;
            m_valid   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        D_BUSY: begin
          if (m_ack) begin
            // A store returns nothing, so the last load word is kept.
            if (!m_we) begin
              d_rdata <= m_rdata;
            end
            d_ready   <= 1'b1;
            m_valid   <= 1'b0;
            state_reg <= IDLE;
          end else if (expire) begin
            d_rdata   <= ERR_DATA;
            d_ready   <= 1'b1;
            bus_err   <= 1'b1;
            m_valid   <= 1'b0;
            state_reg <= IDLE;
          end
        end
        default: begin
          state_reg <= IDLE;
          m_valid   <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_unified_mem_arbiter.sv
// Self-checking bench for unified_mem_arbiter: directed scenarios, an
// access-level reference model checked every cycle, and literal checks.
module tb_unified_mem_arbiter;

  localparam int          TO  = 16;
  localparam logic [31:0] ERR = 32'hE0E0_E0E0;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        i_req = 1'b0;
  logic [31:0] i_addr = '0;
  logic [31:0] i_rdata;
  logic        i_ready;
  logic        d_req = 1'b0;
  logic        d_we = 1'b0;
  logic [31:0] d_addr = '0;
  logic [31:0] d_wdata = '0;
  logic [31:0] d_rdata;
  logic        d_ready;
  logic        m_valid;
  logic        m_we;
  logic [31:0] m_addr;
  logic [31:0] m_wdata;
  logic [31:0] m_rdata = '0;
  logic        m_ack;
  logic        bus_err;

  int n_cmp = 0;
  int n_bad = 0;

  unified_mem_arbiter #(
    .TIMEOUT  (TO),
    .ERR_DATA (ERR)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .i_req   (i_req),
    .i_addr  (i_addr),
    .i_rdata (i_rdata),
    .i_ready (i_ready),
    .d_req   (d_req),
    .d_we    (d_we),
    .d_addr  (d_addr),
    .d_wdata (d_wdata),
    .d_rdata (d_rdata),
    .d_ready (d_ready),
    .m_valid (m_valid),
    .m_we    (m_we),
    .m_addr  (m_addr),
    .m_wdata (m_wdata),
    .m_rdata (m_rdata),
    .m_ack   (m_ack),
    .bus_err (bus_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_bad++;
      $display("FAIL %s: got %08h expected %08h at %0t", name, got, want, $time);
    end
  endtask

  // ---------------- memory responder ----------------
  // Acks the (ack_delay+1)-th busy cycle of each access when ack_en is set.
  bit          ack_en = 1'b1;
  int          ack_delay = 0;
  logic [31:0] ack_data = '0;
  logic        rsp_ack = 1'b0;
  logic        stray_ack = 1'b0;
  int          rsp_cnt = 0;

  assign m_ack = rsp_ack | stray_ack;

  always @(posedge clk) begin
    #1;
    m_rdata = ack_data;
    if (m_valid === 1'b1) begin
      rsp_ack = ack_en && (rsp_cnt == ack_delay);
      rsp_cnt++;
    end else begin
      rsp_ack = 1'b0;
      rsp_cnt = 0;
    end
  end

  // ---------------- reference model ----------------
  // Tracks one outstanding access: who owns it, what it drives, and how
  // many bus cycles it has used. Completion happens on the cycle m_ack is
  // seen, or on the TO-th bus cycle with no ack.
  bit          e_busy = 1'b0;
  bit          e_port = 1'b0;      // 0 = instruction, 1 = data
  logic [31:0] e_addr = '0;
  bit          e_we = 1'b0;
  logic [31:0] e_wdata = '0;
  int          e_cycles = 0;
  bit          e_last_d = 1'b1;    // previous winner was the data port
  bit          e_i_ready = 1'b0;
  bit          e_d_ready = 1'b0;
  logic [31:0] e_i_rdata = '0;
  logic [31:0] e_d_rdata = '0;
  bit          e_bus_err = 1'b0;
  bit          m_i_want;
  bit          m_d_want;

  task automatic model_complete(input logic [31:0] data, input bit aborted);
    e_busy = 1'b0;
    if (aborted) e_bus_err = 1'b1;
    if (e_port == 1'b0) begin
      e_i_ready = 1'b1;
      e_i_rdata = data;
    end else begin
      e_d_ready = 1'b1;
      if (aborted || !e_we) e_d_rdata = data;
    end
  endtask

  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      e_busy = 1'b0; e_port = 1'b0; e_addr = '0; e_we = 1'b0; e_wdata = '0;
      e_cycles = 0; e_last_d = 1'b1; e_i_ready = 1'b0; e_d_ready = 1'b0;
      e_i_rdata = '0; e_d_rdata = '0; e_bus_err = 1'b0;
    end else begin
      m_i_want = i_req && !e_i_ready;
      m_d_want = d_req && !e_d_ready;
      e_i_ready = 1'b0;
      e_d_ready = 1'b0;
      if (!e_busy) begin
        if (m_i_want || m_d_want) begin
          e_busy   = 1'b1;
          e_cycles = 0;
          e_port   = m_d_want && (!m_i_want || !e_last_d);
          e_last_d = e_port;
          e_addr   = e_port ? d_addr : i_addr;
          e_we     = e_port ? d_we : 1'b0;
          e_wdata  = d_wdata;
        end
      end else begin
        e_cycles++;
        if (m_ack) model_complete(m_rdata, 1'b0);
        else if (e_cycles == TO) model_complete(ERR, 1'b1);
      end
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    check("m_valid", 32'(m_valid), 32'(e_busy));
    check("i_ready", 32'(i_ready), 32'(e_i_ready));
    check("d_ready", 32'(d_ready), 32'(e_d_ready));
    check("i_rdata", i_rdata, e_i_rdata);
    check("d_rdata", d_rdata, e_d_rdata);
    check("bus_err", 32'(bus_err), 32'(e_bus_err));
    if (e_busy || !reset) begin
      check("m_addr", m_addr, e_busy ? e_addr : 32'h0);
      check("m_we", 32'(m_we), e_busy ? 32'(e_we) : 32'h0);
    end
    if (!reset) check("m_wdata", m_wdata, 32'h0);
    else if (e_busy && e_we) check("m_wdata", m_wdata, e_wdata);
  end

  // ---------------- driver ----------------
  logic [31:0] c1_addr;
  logic        c1_we;
  logic [31:0] c1_wdata;
  logic        c1_valid;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Requests already set count as cycle 0. Each requester drops its req in
  // the cycle after its ready pulse. Returns the cycle of each ready.
  task automatic run_access(input int max, output int i_at, output int d_at);
    bit want_i = i_req;
    bit want_d = d_req;
    i_at = -1;
    d_at = -1;
    for (int k = 1; k <= max; k++) begin
      tick();
      if (i_at == k - 1) i_req = 1'b0;
      if (d_at == k - 1) d_req = 1'b0;
      if (k == 1) begin
        c1_addr = m_addr; c1_we = m_we; c1_wdata = m_wdata; c1_valid = m_valid;
      end
      if (i_ready && i_at < 0) begin
        i_at = k;
        $display("txn I addr done at cycle %0d rdata %08h bus_err %0b", k, i_rdata, bus_err);
      end
      if (d_ready && d_at < 0) begin
        d_at = k;
        $display("txn D done at cycle %0d rdata %08h bus_err %0b", k, d_rdata, bus_err);
      end
      if ((!want_i || i_at > 0) && (!want_d || d_at > 0) && !i_req && !d_req) break;
    end
    if (want_i && i_at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL i_ready_wait: got no pulse in %0d cycles, expected one", max);
      i_req = 1'b0;
    end
    if (want_d && d_at < 0) begin
      n_cmp++; n_bad++;
      $display("FAIL d_ready_wait: got no pulse in %0d cycles, expected one", max);
      d_req = 1'b0;
    end
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
    tick();
  endtask

  initial begin : watchdog
    #100000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin : stimulus
    int ia;
    int da;
    int pulses;

    repeat (3) @(posedge clk);
    #1;
    check("rst_m_valid", 32'(m_valid), 32'h0);
    check("rst_i_rdata", i_rdata, 32'h0);
    check("rst_bus_err", 32'(bus_err), 32'h0);
    reset = 1'b1;
    tick();

    // Instruction-only fetch, ack in first bus cycle.
    ack_en = 1'b1; ack_delay = 0; ack_data = 32'h2008_0005;
    tick();
    i_addr = 32'h0000_0040; i_req = 1'b1;
    run_access(10, ia, da);
    check("s1_latency", 32'(ia), 32'd2);
    check("s1_m_valid_c1", 32'(c1_valid), 32'd1);
    check("s1_m_addr", c1_addr, 32'h0000_0040);
    check("s1_i_rdata", i_rdata, 32'h2008_0005);

    // Simultaneous requests right after reset: instruction first.
    pulse_reset();
    ack_data = 32'h1111_2222;
    tick();
    i_addr = 32'h0000_0100; d_addr = 32'h0000_0200; d_we = 1'b0;
    i_req = 1'b1; d_req = 1'b1;
    run_access(20, ia, da);
    check("s2_i_first", 32'(ia), 32'd2);
    check("s2_d_second", 32'(da), 32'd4);
    check("s2_first_addr", c1_addr, 32'h0000_0100);
    check("s2_d_rdata", d_rdata, 32'h1111_2222);

    // Store: data goes out, d_rdata keeps the previous load word.
    ack_data = 32'hDEAD_BEEF;
    tick();
    d_addr = 32'h0000_0010; d_wdata = 32'hCAFE_F00D; d_we = 1'b1; d_req = 1'b1;
    run_access(10, ia, da);
    check("s3_latency", 32'(da), 32'd2);
    check("s3_m_we", 32'(c1_we), 32'd1);
    check("s3_m_wdata", c1_wdata, 32'hCAFE_F00D);
    check("s3_m_addr", c1_addr, 32'h0000_0010);
    check("s3_d_rdata_kept", d_rdata, 32'h1111_2222);
    d_we = 1'b0;

    // Memory never answers: 16 bus cycles, then ERR_DATA and sticky bus_err.
    ack_en = 1'b0;
    tick();
    i_addr = 32'h0000_0080; i_req = 1'b1;
    run_access(40, ia, da);
    check("s4_timeout_cycle", 32'(ia), 32'd17);
    check("s4_err_data", i_rdata, ERR);
    check("s4_bus_err", 32'(bus_err), 32'd1);
    ack_en = 1'b1; ack_data = 32'h3333_4444;
    tick();
    d_addr = 32'h0000_0020; d_req = 1'b1;
    run_access(10, ia, da);
    check("s4_after_latency", 32'(da), 32'd2);
    check("s4_after_rdata", d_rdata, 32'h3333_4444);
    check("s4_bus_err_sticky", 32'(bus_err), 32'd1);

    // Ack lands on the last allowed bus cycle: normal completion.
    pulse_reset();
    ack_delay = TO - 1; ack_data = 32'h5555_6666;
    tick();
    d_addr = 32'h0000_0030; d_req = 1'b1;
    run_access(40, ia, da);
    check("s5_cycle", 32'(da), 32'd17);
    check("s5_rdata", d_rdata, 32'h5555_6666);
    check("s5_no_bus_err", 32'(bus_err), 32'd0);

    // Stray ack while idle must do nothing.
    ack_delay = 0;
    stray_ack = 1'b1;
    tick();
    stray_ack = 1'b0;
    check("s6_no_i_ready", 32'(i_ready), 32'd0);
    check("s6_no_d_ready", 32'(d_ready), 32'd0);
    check("s6_no_valid", 32'(m_valid), 32'd0);

    // Request withdrawn mid-access still completes.
    ack_delay = 3; ack_data = 32'h7777_8888;
    tick();
    d_addr = 32'h0000_0044; d_req = 1'b1;
    tick();
    tick();
    d_req = 1'b0;
    da = -1;
    for (int k = 3; k <= 12; k++) begin
      tick();
      if (d_ready && da < 0) begin
        da = k;
        $display("txn D (dropped req) done at cycle %0d rdata %08h", k, d_rdata);
      end
    end
    check("s7_cycle", 32'(da), 32'd5);
    check("s7_rdata", d_rdata, 32'h7777_8888);

    // Reset while the data access is outstanding.
    ack_en = 1'b0; ack_delay = 0;
    tick();
    d_addr = 32'h0000_0050; d_req = 1'b1;
    tick();
    tick();
    tick();
    check("s8_busy_before", 32'(m_valid), 32'd1);
    reset = 1'b0;
    d_req = 1'b0;
    #1;
    check("s8_valid_dropped", 32'(m_valid), 32'd0);
    check("s8_no_d_ready", 32'(d_ready), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    pulses = 0;
    for (int k = 0; k < 5; k++) begin
      tick();
      if (d_ready) pulses++;
    end
    check("s8_no_late_ready", 32'(pulses), 32'd0);
    ack_en = 1'b1; ack_data = 32'h9999_AAAA;
    tick();
    i_addr = 32'h0000_0060; i_req = 1'b1;
    run_access(10, ia, da);
    check("s8_idle_after", 32'(ia), 32'd2);
    check("s8_i_rdata", i_rdata, 32'h9999_AAAA);

    tick();
    tick();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/unified_mem_arbiter.md
UNIFIED_MEM_ARBITER -- requirements
Module: unified_mem_arbiter

Interface
REQ-001 SHALL have parameter TIMEOUT, default 16: cycles in a busy state without m_ack before abort.
REQ-002 SHALL have parameter ERR_DATA, default 32'h0000_0000: read data returned on an aborted access.
REQ-003 SHALL use one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset  input  1  asynchronous, active-low reset.
REQ-006 i_req  input  1  instruction fetch request; held until i_ready.
REQ-007 i_addr  input  32  fetch byte address.
REQ-008 i_rdata  output  32  fetched word; valid with i_ready and held until the next instruction completion.
REQ-009 i_ready  output  1  one-cycle completion pulse, instruction port.
REQ-010 d_req  input  1  data request (load or store); held until d_ready.
REQ-011 d_we  input  1  1 = store, 0 = load.
REQ-012 d_addr  input  32  data byte address.
REQ-013 d_wdata  input  32  store data.
REQ-014 d_rdata  output  32  load word; valid with d_ready and held until the next data completion.
REQ-015 d_ready  output  1  one-cycle completion pulse, data port.
REQ-016 m_valid  output  1  memory access in progress.
REQ-017 m_we  output  1  memory write enable.
REQ-018 m_addr  output  32  memory address.
REQ-019 m_wdata  output  32  memory write data.
REQ-020 m_rdata  input  32  memory read data; sampled with m_ack.
REQ-021 m_ack  input  1  memory completion, one cycle.
REQ-022 bus_err  output  1  sticky timeout flag.

Function
REQ-023 SHALL implement FSM states IDLE, I_BUSY, D_BUSY.
REQ-024 In IDLE with both requests live: grant data if last_grant = I, else grant instruction; with one live request, grant it.
REQ-025 A port whose ready pulses in the current cycle SHALL be masked from arbitration in that cycle.
REQ-026 On grant SHALL register m_addr, m_we (d_we for data, 0 for instruction) and m_wdata, and update last_grant.
REQ-027 In I_BUSY or D_BUSY, m_valid = 1 and m_addr, m_we, m_wdata SHALL stay stable.
REQ-028 On m_ack in a busy state SHALL capture m_rdata into the granted port's rdata, pulse that port's ready in the next cycle, and return to IDLE.
REQ-029 Minimum latency SHALL be: req sampled in cycle 0, m_valid in cycle 1, m_ack in cycle 1, ready in cycle 2.
REQ-030 Store completion SHALL leave d_rdata unchanged.
REQ-031 Timeout counter SHALL clear on grant and increment each busy cycle without m_ack.
REQ-032 At count = TIMEOUT-1 with no m_ack SHALL: abort, set bus_err, load ERR_DATA into the port's rdata, pulse ready, and go to IDLE.
REQ-033 m_ack in the timeout cycle SHALL take precedence: normal completion, no error.
REQ-034 A request dropped mid-access SHALL still complete, and ready SHALL still pulse.
REQ-035 m_ack in IDLE SHALL be ignored.

Reset
REQ-036 On reset SHALL clear: state = IDLE, last_grant = D, all outputs = 0, bus_err = 0, counter = 0.
REQ-037 Reset mid-access SHALL abandon the access without a ready pulse.

Structure
REQ-038 Package mem_arb_pkg SHALL hold the state enum, the grant enum {GNT_I, GNT_D} and the default TIMEOUT.
REQ-039 Timeout counter SHALL be sub-module arb_timeout_ctr (clear, enable, expire).

Verification
REQ-040 Bench SHALL cover: i_req only, i_addr = 0x0000_0040, memory acks in cycle 1 with 0x2008_0005 -> i_ready in cycle 2, i_rdata = 0x2008_0005.
REQ-041 Bench SHALL cover: i_req and d_req in the same cycle after reset -> instruction granted first, then data, with no overlap of m_valid.
REQ-042 Bench SHALL cover: store d_addr = 0x10, d_wdata = 0xCAFE_F00D -> m_we = 1, m_wdata = 0xCAFE_F00D, d_ready pulses, d_rdata unchanged.
REQ-043 Bench SHALL cover: memory never acks, TIMEOUT = 16 -> ready 16 cycles after grant, rdata = ERR_DATA, bus_err = 1 sticky.
REQ-044 Bench SHALL cover: m_ack on the timeout cycle -> normal data returned, bus_err = 0.
REQ-045 Bench SHALL cover: reset asserted while in D_BUSY -> next cycle IDLE, m_valid = 0, no d_ready.
